// File: rtl/regfile_sb_if.sv
// ============================================================================
// regfile_sb_if : read/write/lock port bundle for regfile_sb. Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic                rd_busy_a;
  logic                rd_busy_b;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                lock_en;
  logic [ADDR_W-1:0]   lock_addr;
  logic                lock_ok;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, lock_en, lock_addr,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, lock_ok, busy_vec
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, lock_en, lock_addr,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, lock_ok, busy_vec
  );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// regfile_sb : 2R/1W register file with lock/release scoreboard. Rev 1.0
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  wire logic   CLK,
  input  wire logic   areset_n,
  regfile_sb_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                w_wr_fire;
  logic                w_lock_ok;
  logic                w_lock_set;

  // Register 0 absorbs writes and locks when hardwired to zero.
  assign w_wr_fire  = bus.wr_en &&
                      !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign w_lock_ok  = bus.lock_en && areset_n &&
                      (!busy_q[bus.lock_addr] ||
                       (bus.wr_en && (bus.wr_addr == bus.lock_addr)));
  assign w_lock_set = w_lock_ok &&
                      !((ZERO_REG != 0) && (bus.lock_addr == '0));

  // Set is applied after clear so a same-cycle lock keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (w_wr_fire) begin
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (w_lock_set) begin
      busy_d[bus.lock_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!areset_n) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      if (w_wr_fire) begin
        regs_q[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  always_comb begin
    bus.rd_data_a = regs_q[bus.rd_addr_a];
    bus.rd_busy_a = busy_q[bus.rd_addr_a];
    if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) begin
      bus.rd_data_a = '0;
      bus.rd_busy_a = 1'b0;
    end else if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
      bus.rd_data_a = bus.wr_data;
      bus.rd_busy_a = w_lock_ok && (bus.lock_addr == bus.rd_addr_a);
    end
  end

  always_comb begin
    bus.rd_data_b = regs_q[bus.rd_addr_b];
    bus.rd_busy_b = busy_q[bus.rd_addr_b];
    if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) begin
      bus.rd_data_b = '0;
      bus.rd_busy_b = 1'b0;
    end else if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
      bus.rd_data_b = bus.wr_data;
      bus.rd_busy_b = w_lock_ok && (bus.lock_addr == bus.rd_addr_b);
    end
  end

  assign bus.lock_ok  = w_lock_ok;
  assign bus.busy_vec = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// tb_regfile_sb : directed vectors on a bypass build and a zero-reg build. Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sb;
  logic CLK;
  logic areset_n;

  regfile_sb_if #(.DATA_W(8), .ADDR_W(2)) if_a ();
  regfile_sb_if #(.DATA_W(8), .ADDR_W(2)) if_b ();

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u_dut_a (
    .CLK      (CLK),
    .areset_n (areset_n),
    .bus      (if_a.slave)
  );

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .CLK      (CLK),
    .areset_n (areset_n),
    .bus      (if_b.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] rd_a, rd_b;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       lock_en;
    logic [1:0] lock_addr;
    logic [7:0] a_da, a_db;
    logic       a_ba, a_bb, a_ok;
    logic [7:0] b_da;
    logic       b_ba, b_ok;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ra, input logic [1:0] rb, input logic we,
                       input logic [1:0] wa, input logic [7:0] wd,
                       input logic le, input logic [1:0] la);
    if_a.rd_addr_a = ra; if_b.rd_addr_a = ra;
    if_a.rd_addr_b = rb; if_b.rd_addr_b = rb;
    if_a.wr_en     = we; if_b.wr_en     = we;
    if_a.wr_addr   = wa; if_b.wr_addr   = wa;
    if_a.wr_data   = wd; if_b.wr_data   = wd;
    if_a.lock_en   = le; if_b.lock_en   = le;
    if_a.lock_addr = la; if_b.lock_addr = la;
  endtask

  task automatic idle(input logic [1:0] ra, input logic [1:0] rb);
    drive(ra, rb, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic [1:0] ra, input logic [1:0] rb, input logic we,
                     input logic [1:0] wa, input logic [7:0] wd,
                     input logic le, input logic [1:0] la,
                     input logic [7:0] a_da, input logic [7:0] a_db,
                     input logic a_ba, input logic a_bb, input logic a_ok,
                     input logic [7:0] b_da, input logic b_ba, input logic b_ok);
    vec_t v;
    v.rd_a = ra; v.rd_b = rb; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.lock_en = le; v.lock_addr = la;
    v.a_da = a_da; v.a_db = a_db; v.a_ba = a_ba; v.a_bb = a_bb; v.a_ok = a_ok;
    v.b_da = b_da; v.b_ba = b_ba; v.b_ok = b_ok;
    vq.push_back(v);
  endtask

  initial begin
    // Stored state when the table runs: r0..r3 = 10,21,32,43 (B: r0 = 0), busy = 4'b1000.
    add(2'd1, 2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h21, 8'h32, 1'b0, 1'b0, 1'b0, 8'h21, 1'b0, 1'b0);
    add(2'd3, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h43, 8'h43, 1'b1, 1'b1, 1'b0, 8'h43, 1'b1, 1'b0);
    add(2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h10, 8'h21, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    add(2'd1, 2'd2, 1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 8'h3C, 8'h32, 1'b0, 1'b0, 1'b0, 8'h21, 1'b0, 1'b0);
    add(2'd3, 2'd3, 1'b1, 2'd3, 8'h5A, 1'b0, 2'd0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h43, 1'b1, 1'b0);
    add(2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h43, 8'h10, 1'b1, 1'b0, 1'b0, 8'h43, 1'b1, 1'b0);
    add(2'd3, 2'd3, 1'b1, 2'd3, 8'h77, 1'b1, 2'd3, 8'h77, 8'h77, 1'b1, 1'b1, 1'b1, 8'h43, 1'b1, 1'b1);
    add(2'd2, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h32, 8'h10, 1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 1'b1);
    add(2'd0, 2'd0, 1'b1, 2'd0, 8'hFF, 1'b1, 2'd0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    add(2'd1, 2'd2, 1'b1, 2'd1, 8'h99, 1'b1, 2'd2, 8'h99, 8'h32, 1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
    add(2'd2, 2'd2, 1'b1, 2'd2, 8'h55, 1'b1, 2'd2, 8'h55, 8'h55, 1'b1, 1'b1, 1'b1, 8'h32, 1'b0, 1'b1);

    // Reset, with a lock request held during the reset cycle.
    areset_n = 1'b0;
    drive(2'd0, 2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    #1;
    chk("rst_lock_ok_a", 32'(if_a.lock_ok), 32'd0);
    chk("rst_lock_ok_b", 32'(if_b.lock_ok), 32'd0);
    tick();
    idle(2'd0, 2'd1);
    #1;
    chk("rst_busy_a", 32'(if_a.busy_vec), 32'd0);
    chk("rst_busy_b", 32'(if_b.busy_vec), 32'd0);
    chk("rst_da_a", 32'(if_a.rd_data_a), 32'd0);
    chk("rst_db_a", 32'(if_a.rd_data_b), 32'd0);
    chk("rst_rbusy_a", 32'({if_a.rd_busy_a, if_a.rd_busy_b}), 32'd0);
    areset_n = 1'b1;

    // Write A5 to r2, read on both ports next cycle.
    drive(2'd2, 2'd2, 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0);
    tick();
    idle(2'd2, 2'd2);
    #1;
    chk("wr_r2_da_a", 32'(if_a.rd_data_a), 32'hA5);
    chk("wr_r2_db_a", 32'(if_a.rd_data_b), 32'hA5);
    chk("wr_r2_da_b", 32'(if_b.rd_data_a), 32'hA5);
    chk("wr_r2_db_b", 32'(if_b.rd_data_b), 32'hA5);
    chk("wr_r2_busy_a", 32'({if_a.rd_busy_a, if_a.rd_busy_b}), 32'd0);

    // Preload and lock r3.
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 2'd0, 1'b1, 2'(i), 8'(8'h10 + 8'h11 * i), 1'b0, 2'd0);
      tick();
    end
    drive(2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    #1;
    chk("lock_r3_ok_a", 32'(if_a.lock_ok), 32'd1);
    chk("lock_r3_ok_b", 32'(if_b.lock_ok), 32'd1);
    tick();
    idle(2'd0, 2'd0);
    #1;
    chk("lock_r3_busy_a", 32'(if_a.busy_vec), 32'h8);
    chk("lock_r3_busy_b", 32'(if_b.busy_vec), 32'h8);

    // Combinational table: inputs withdrawn before each edge, so state is unchanged.
    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].rd_a, vq[k].rd_b, vq[k].wr_en, vq[k].wr_addr, vq[k].wr_data,
            vq[k].lock_en, vq[k].lock_addr);
      #1;
      chk($sformatf("v%0d_da_a", k), 32'(if_a.rd_data_a), 32'(vq[k].a_da));
      chk($sformatf("v%0d_db_a", k), 32'(if_a.rd_data_b), 32'(vq[k].a_db));
      chk($sformatf("v%0d_ba_a", k), 32'(if_a.rd_busy_a), 32'(vq[k].a_ba));
      chk($sformatf("v%0d_bb_a", k), 32'(if_a.rd_busy_b), 32'(vq[k].a_bb));
      chk($sformatf("v%0d_ok_a", k), 32'(if_a.lock_ok),   32'(vq[k].a_ok));
      chk($sformatf("v%0d_da_b", k), 32'(if_b.rd_data_a), 32'(vq[k].b_da));
      chk($sformatf("v%0d_ba_b", k), 32'(if_b.rd_busy_a), 32'(vq[k].b_ba));
      chk($sformatf("v%0d_ok_b", k), 32'(if_b.lock_ok),   32'(vq[k].b_ok));
      idle(2'd0, 2'd0);
      tick();
    end

    // Release r3 by writing 0x11.
    drive(2'd0, 2'd0, 1'b1, 2'd3, 8'h11, 1'b0, 2'd0);
    tick();
    idle(2'd3, 2'd3);
    #1;
    chk("rel_busy_a", 32'(if_a.busy_vec), 32'd0);
    chk("rel_busy_b", 32'(if_b.busy_vec), 32'd0);
    chk("rel_r3_a", 32'(if_a.rd_data_a), 32'h11);
    chk("rel_r3_b", 32'(if_b.rd_data_b), 32'h11);

    // Write-to-read latency: bypass build same cycle, non-bypass build one cycle later.
    drive(2'd1, 2'd1, 1'b1, 2'd1, 8'h3C, 1'b0, 2'd0);
    #1;
    chk("byp_now_a", 32'(if_a.rd_data_a), 32'h3C);
    chk("byp_now_b", 32'(if_b.rd_data_a), 32'h21);
    tick();
    idle(2'd1, 2'd1);
    #1;
    chk("byp_next_b", 32'(if_b.rd_data_a), 32'h3C);

    // Lock r2, then lock r2 again with a same-cycle write of 0x77.
    drive(2'd2, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    tick();
    idle(2'd2, 2'd2);
    #1;
    chk("l2_busy_a", 32'(if_a.busy_vec), 32'h4);
    chk("l2_busy_b", 32'(if_b.busy_vec), 32'h4);
    drive(2'd2, 2'd2, 1'b1, 2'd2, 8'h77, 1'b1, 2'd2);
    #1;
    chk("l2w_ok_a", 32'(if_a.lock_ok), 32'd1);
    chk("l2w_ok_b", 32'(if_b.lock_ok), 32'd1);
    tick();
    idle(2'd2, 2'd2);
    #1;
    chk("l2w_busy_a", 32'(if_a.busy_vec), 32'h4);
    chk("l2w_busy_b", 32'(if_b.busy_vec), 32'h4);
    chk("l2w_r2_a", 32'(if_a.rd_data_a), 32'h77);
    chk("l2w_r2_b", 32'(if_b.rd_data_a), 32'h77);
    chk("l2w_rb_a", 32'(if_a.rd_busy_a), 32'd1);

    // Write 0xFF and lock r0: zero-reg build ignores both, the other does not.
    drive(2'd0, 2'd0, 1'b1, 2'd0, 8'hFF, 1'b1, 2'd0);
    #1;
    chk("z_ok_b", 32'(if_b.lock_ok), 32'd1);
    chk("z_da_b", 32'(if_b.rd_data_a), 32'd0);
    chk("z_ba_b", 32'(if_b.rd_busy_a), 32'd0);
    tick();
    idle(2'd0, 2'd0);
    #1;
    chk("z_busy_b", 32'(if_b.busy_vec), 32'h4);
    chk("z_r0_b", 32'(if_b.rd_data_a), 32'd0);
    chk("z_busy_a", 32'(if_a.busy_vec), 32'h5);
    chk("z_r0_a", 32'(if_a.rd_data_a), 32'hFF);

    // Reset with locks outstanding.
    drive(2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    tick();
    idle(2'd0, 2'd0);
    #1;
    chk("pre_rst_busy_a", 32'(if_a.busy_vec), 32'h7);
    chk("pre_rst_busy_b", 32'(if_b.busy_vec), 32'h6);
    areset_n = 1'b0;
    drive(2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    #1;
    chk("mrst_ok_a", 32'(if_a.lock_ok), 32'd0);
    chk("mrst_ok_b", 32'(if_b.lock_ok), 32'd0);
    tick();
    areset_n = 1'b1;
    idle(2'd1, 2'd2);
    #1;
    chk("mrst_busy_a", 32'(if_a.busy_vec), 32'd0);
    chk("mrst_busy_b", 32'(if_b.busy_vec), 32'd0);
    chk("mrst_r1r2_a", 32'({if_a.rd_data_a, if_a.rd_data_b}), 32'd0);
    chk("mrst_r1r2_b", 32'({if_b.rd_data_a, if_b.rd_data_b}), 32'd0);
    idle(2'd0, 2'd3);
    #1;
    chk("mrst_r0r3_a", 32'({if_a.rd_data_a, if_a.rd_data_b}), 32'd0);
    chk("mrst_rbusy_a", 32'({if_a.rd_busy_a, if_a.rd_busy_b}), 32'd0);
    drive(2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    #1;
    chk("post_ok_a", 32'(if_a.lock_ok), 32'd1);
    tick();
    idle(2'd0, 2'd0);
    #1;
    chk("post_busy_a", 32'(if_a.busy_vec), 32'h4);
    chk("post_busy_b", 32'(if_b.busy_vec), 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
